// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM compare stage.
//   pwm_state_e    : compare-stage operating state (IDLE, ARM, RUN)
//   PWM_N_DEFAULT  : default counter width
//   pwm_period/max : period length (2**n) and largest counter value (2**n-1)
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } pwm_state_e;

    localparam int unsigned PWM_N_DEFAULT = 32'd5;

    function automatic int unsigned pwm_period(input int unsigned n);
        return 32'd1 << n;
    endfunction

    function automatic int unsigned pwm_max(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_wrap_detect.sv
// Wrap / discontinuity detector for the upstream free-running counter.
// Keeps the previous counter sample and classifies the current one.
//   clk, rst       : clock, asynchronous active-high reset
//   cnt            : counter value from upstream
//   wrap           : previous sample was MAX and current is 0
//   discontinuity  : current value is neither prev+1 (mod 2**N) nor a wrap
module pwm_wrap_detect
    import pwm_pkg::*;
#(
    parameter int unsigned N = PWM_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cnt,
    output logic         wrap,
    output logic         discontinuity
);

    localparam logic [N-1:0] CNT_MAX  = N'(pwm_max(N));
    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] prev_cnt_r;
    logic         wrap_s;
    logic         step_s;

    // Previous counter sample, refreshed every clock in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cnt_r <= CNT_ZERO;
        end else begin
            prev_cnt_r <= cnt;
        end
    end

    // Classify the current sample; the N-bit add wraps naturally mod 2**N.
    always_comb begin
        wrap_s = (prev_cnt_r == CNT_MAX) && (cnt == CNT_ZERO);
        step_s = (cnt == (prev_cnt_r + CNT_ONE)) || wrap_s;
    end

    assign wrap          = wrap_s;
    assign discontinuity = ~step_s;

endmodule

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: compares the upstream counter with a double-buffered
// duty register and produces a registered PWM output, period/match pulses
// and a sticky period interrupt. Duty updates are accepted over valid/ready
// into a one-entry pending buffer and become active only at a counter wrap.
//   clk, rst      : clock, asynchronous active-high reset
//   cnt           : counter value (N bits), one step per clock
//   en            : run enable, 0 forces IDLE
//   duty_data     : requested duty in clocks (N+1 bits, saturates at 2**N)
//   duty_valid    : duty_data valid
//   duty_ready    : pending buffer empty
//   pwm_out       : registered PWM output, active level POL
//   period_pulse  : one-clock pulse per wrap while ARM/RUN
//   match_pulse   : one-clock pulse when cnt reaches the active duty in RUN
//   irq           : sticky period interrupt
//   irq_clr       : clears irq (a simultaneous set wins)
module pwm_compare_stage
    import pwm_pkg::*;
#(
    parameter int unsigned N   = PWM_N_DEFAULT,
    parameter bit          POL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cnt,
    input  logic         en,
    input  logic [N:0]   duty_data,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         pwm_out,
    output logic         period_pulse,
    output logic         match_pulse,
    output logic         irq,
    input  logic         irq_clr
);

    localparam logic [N:0] PERIOD    = (N+1)'(pwm_period(N));
    localparam logic [N:0] DUTY_ZERO = {(N+1){1'b0}};
    localparam logic       ACT       = POL;
    localparam logic       INACT     = ~POL;

    // Clamp a requested duty to the full period.
    function automatic logic [N:0] sat_duty(input logic [N:0] d);
        if (d > PERIOD) begin
            return PERIOD;
        end else begin
            return d;
        end
    endfunction

    pwm_state_e  state_r;
    pwm_state_e  state_next_s;
    logic [N:0]  duty_active_r;
    logic [N:0]  pending_r;
    logic        duty_ready_r;
    logic        pwm_r;
    logic        period_pulse_r;
    logic        match_pulse_r;
    logic        irq_r;

    logic        wrap_s;
    logic        disc_s;
    logic [N:0]  cnt_ext_s;
    logic        armed_s;
    logic        load_s;
    logic        accept_s;
    logic [N:0]  duty_eff_s;
    logic        pwm_next_s;
    logic        period_next_s;
    logic        match_next_s;
    logic        irq_next_s;
    logic        ready_next_s;

    pwm_wrap_detect #(.N(N)) u_wrap_detect (
        .clk           (clk),
        .rst           (rst),
        .cnt           (cnt),
        .wrap          (wrap_s),
        .discontinuity (disc_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; dropping en overrides wrap and discontinuity.
    always_comb begin
        state_next_s = state_r;
        if (!en) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_next_s = ARM;
                ARM: begin
                    if (wrap_s) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = ARM;
                    end
                end
                RUN: begin
                    if (disc_s) begin
                        state_next_s = ARM;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Duty buffer control. On a reloading wrap the new duty already governs
    // cnt == 0, so each period uses a single duty value from its first clock.
    always_comb begin
        cnt_ext_s  = {1'b0, cnt};
        armed_s    = (state_r == ARM) || (state_r == RUN);
        load_s     = wrap_s && en && armed_s && !duty_ready_r;
        accept_s   = duty_valid && duty_ready_r;
        if (load_s) begin
            duty_eff_s = pending_r;
        end else begin
            duty_eff_s = duty_active_r;
        end
        if (load_s) begin
            ready_next_s = 1'b1;
        end else if (accept_s) begin
            ready_next_s = 1'b0;
        end else begin
            ready_next_s = duty_ready_r;
        end
    end

    // Next values of the registered outputs. Duty 0 and full-period duty
    // have no falling edge, so they never raise match_pulse.
    always_comb begin
        if ((state_r == RUN) && en && !disc_s) begin
            if (cnt_ext_s < duty_eff_s) begin
                pwm_next_s = ACT;
            end else begin
                pwm_next_s = INACT;
            end
        end else begin
            pwm_next_s = INACT;
        end
        period_next_s = wrap_s && armed_s;
        match_next_s  = (state_r == RUN) && (duty_eff_s != DUTY_ZERO) &&
                        (duty_eff_s < PERIOD) && (cnt_ext_s == duty_eff_s);
        if (period_pulse_r) begin
            irq_next_s = 1'b1;
        end else if (irq_clr) begin
            irq_next_s = 1'b0;
        end else begin
            irq_next_s = irq_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_active_r  <= DUTY_ZERO;
            pending_r      <= DUTY_ZERO;
            duty_ready_r   <= 1'b1;
            pwm_r          <= INACT;
            period_pulse_r <= 1'b0;
            match_pulse_r  <= 1'b0;
            irq_r          <= 1'b0;
        end else begin
            if (load_s) begin
                duty_active_r <= pending_r;
            end
            if (accept_s) begin
                pending_r <= sat_duty(duty_data);
            end
            duty_ready_r   <= ready_next_s;
            pwm_r          <= pwm_next_s;
            period_pulse_r <= period_next_s;
            match_pulse_r  <= match_next_s;
            irq_r          <= irq_next_s;
        end
    end

    assign duty_ready   = duty_ready_r;
    assign pwm_out      = pwm_r;
    assign period_pulse = period_pulse_r;
    assign match_pulse  = match_pulse_r;
    assign irq          = irq_r;

endmodule
